// File: rtl/riscv_core_rob_alloc_ctrl_if.sv
// ROB allocation request bus between the allocation controller (master)
// and the 2-wide reorder buffer / rename table (slave).
interface riscv_core_rob_alloc_ctrl_if;
    logic       rob_alloc_req_val_1;
    logic       rob_alloc_req_val_2;
    logic       rob_alloc_req_wen_1;
    logic       rob_alloc_req_wen_2;
    logic       rob_alloc_req_spec_1;
    logic       rob_alloc_req_spec_2;
    logic [4:0] rob_alloc_req_preg_1;
    logic [4:0] rob_alloc_req_preg_2;
    logic       rob_alloc_req_rdy;

    modport master (
        output rob_alloc_req_val_1, rob_alloc_req_val_2,
        output rob_alloc_req_wen_1, rob_alloc_req_wen_2,
        output rob_alloc_req_spec_1, rob_alloc_req_spec_2,
        output rob_alloc_req_preg_1, rob_alloc_req_preg_2,
        input  rob_alloc_req_rdy
    );

    modport slave (
        input  rob_alloc_req_val_1, rob_alloc_req_val_2,
        input  rob_alloc_req_wen_1, rob_alloc_req_wen_2,
        input  rob_alloc_req_spec_1, rob_alloc_req_spec_2,
        input  rob_alloc_req_preg_1, rob_alloc_req_preg_2,
        output rob_alloc_req_rdy
    );
endinterface

// File: rtl/riscv_core_rob_alloc_ctrl.sv
// Dual-issue ROB allocation controller: decides which of two in-order
// decoded instructions enter the ROB, tracks ROB occupancy with a credit
// counter and runs a single-branch speculation FSM.
// Optional macro RISCV_ROB_ALLOC_PERF_EN adds stall performance counters.
module riscv_core_rob_alloc_ctrl #(
    parameter int ROB_DEPTH = 32,
    parameter int OCC_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_val_1,
    input  logic             inst_wen_1,
    input  logic [4:0]       inst_waddr_1,
    input  logic             inst_brj_1,
    input  logic             inst_val_2,
    input  logic             inst_wen_2,
    input  logic [4:0]       inst_waddr_2,
    input  logic             inst_brj_2,
    output logic             inst_acc_1,
    output logic             inst_acc_2,
    riscv_core_rob_alloc_ctrl_if.master rob,
    input  logic [1:0]       rob_commit_cnt,
    input  logic             brj_resolved,
    input  logic             brj_taken,
    output logic [OCC_W-1:0] rob_occupancy,
    output logic             spec_active,
    output logic             occ_err
`ifdef RISCV_ROB_ALLOC_PERF_EN
    ,
    output logic [31:0]      perf_full_stalls,
    output logic [31:0]      perf_brj_stalls
`endif
);

    typedef enum logic {NORM = 1'b0, SPEC = 1'b1} state_t;

    localparam logic [OCC_W:0] DEPTH_X = (OCC_W+1)'(ROB_DEPTH);

    state_t         state;
    logic [OCC_W:0] free_cnt;
    logic           cap_ok;
    logic           go;
    logic           in_spec;
    logic [OCC_W:0] occ_plus;
    logic [OCC_W:0] commit_x;
    logic [OCC_W:0] occ_diff;
    logic           occ_under;
    logic           occ_over;

    // Squashing a taken branch is the ROB's job; the outcome is not needed here.
    logic unused_brj_taken;
    assign unused_brj_taken = brj_taken;

    assign in_spec  = (state == SPEC);
    assign free_cnt = DEPTH_X - {1'b0, rob_occupancy};
    assign cap_ok   = rob.rob_alloc_req_rdy && (free_cnt >= (OCC_W+1)'(2));
    // Resolution cycles allocate nothing so a squash never races an allocation.
    assign go       = cap_ok && !brj_resolved;

    // Acceptance and ROB request drive; everything forced low during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        inst_acc_1               = 1'b0;
        inst_acc_2               = 1'b0;
        rob.rob_alloc_req_val_1  = 1'b0;
        rob.rob_alloc_req_val_2  = 1'b0;
        rob.rob_alloc_req_wen_1  = 1'b0;
        rob.rob_alloc_req_wen_2  = 1'b0;
        rob.rob_alloc_req_spec_1 = 1'b0;
        rob.rob_alloc_req_spec_2 = 1'b0;
        rob.rob_alloc_req_preg_1 = 5'd0;
        rob.rob_alloc_req_preg_2 = 5'd0;
        if (!reset) begin
            inst_acc_1 = go && inst_val_1 && !(inst_brj_1 && in_spec);
            // Slot 2 never overtakes slot 1 and never opens a second branch.
            inst_acc_2 = go && inst_val_2 && (inst_acc_1 || !inst_val_1) &&
                         !(inst_brj_2 && (in_spec || (inst_acc_1 && inst_brj_1)));
            rob.rob_alloc_req_val_1  = inst_acc_1;
            rob.rob_alloc_req_val_2  = inst_acc_2;
            rob.rob_alloc_req_wen_1  = inst_wen_1 && (inst_waddr_1 != 5'd0);
            rob.rob_alloc_req_wen_2  = inst_wen_2 && (inst_waddr_2 != 5'd0);
            rob.rob_alloc_req_preg_1 = inst_waddr_1;
            rob.rob_alloc_req_preg_2 = inst_waddr_2;
            rob.rob_alloc_req_spec_1 = in_spec;
            rob.rob_alloc_req_spec_2 = in_spec || (inst_acc_1 && inst_brj_1);
        end
    end

    // Next occupancy with underflow/overflow detection, one bit wider than the counter.
    always_comb begin
        occ_plus  = {1'b0, rob_occupancy} + (OCC_W+1)'(inst_acc_1) + (OCC_W+1)'(inst_acc_2);
        commit_x  = (OCC_W+1)'(rob_commit_cnt);
        occ_under = (occ_plus < commit_x);
        occ_diff  = occ_plus - commit_x;
        occ_over  = !occ_under && (occ_diff > DEPTH_X);
    end

    assign spec_active = in_spec;

    // Speculation FSM, occupancy credit counter and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state         <= NORM;
            rob_occupancy <= '0;
            occ_err       <= 1'b0;
        end else begin
            case (state)
                NORM: if ((inst_acc_1 && inst_brj_1) || (inst_acc_2 && inst_brj_2)) state <= SPEC;
                SPEC: if (brj_resolved) state <= NORM;
                default: state <= NORM;
            endcase
            if (occ_under) begin
                occ_err       <= 1'b1;
                rob_occupancy <= '0;
            end else if (occ_over) begin
                occ_err       <= 1'b1;
                rob_occupancy <= OCC_W'(ROB_DEPTH);
            end else begin
                rob_occupancy <= occ_diff[OCC_W-1:0];
            end
        end
    end

`ifdef RISCV_ROB_ALLOC_PERF_EN
    logic full_stall;
    logic brj_stall;

    assign full_stall = (inst_val_1 || inst_val_2) && !cap_ok;
    assign brj_stall  = go && in_spec &&
                        ((inst_val_1 && inst_brj_1) ||
                         (inst_val_2 && inst_brj_2 && (inst_acc_1 || !inst_val_1)));

    // Free-running stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_full_stalls <= '0;
            perf_brj_stalls  <= '0;
        end else begin
            if (full_stall) perf_full_stalls <= perf_full_stalls + 32'd1;
            if (brj_stall)  perf_brj_stalls  <= perf_brj_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_rob_alloc_ctrl.sv
// Self-checking bench for riscv_core_rob_alloc_ctrl: directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_riscv_core_rob_alloc_ctrl;
    localparam int ROB_DEPTH = 32;
    localparam int OCC_W     = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             inst_val_1, inst_wen_1, inst_brj_1;
    logic [4:0]       inst_waddr_1;
    logic             inst_val_2, inst_wen_2, inst_brj_2;
    logic [4:0]       inst_waddr_2;
    logic             inst_acc_1, inst_acc_2;
    logic [1:0]       rob_commit_cnt;
    logic             brj_resolved, brj_taken;
    logic [OCC_W-1:0] rob_occupancy;
    logic             spec_active, occ_err;
`ifdef RISCV_ROB_ALLOC_PERF_EN
    logic [31:0]      perf_full_stalls, perf_brj_stalls;
`endif

    riscv_core_rob_alloc_ctrl_if rob_if ();

    riscv_core_rob_alloc_ctrl #(.ROB_DEPTH(ROB_DEPTH), .OCC_W(OCC_W)) dut (
        .clk(clk), .reset(reset),
        .inst_val_1(inst_val_1), .inst_wen_1(inst_wen_1), .inst_waddr_1(inst_waddr_1), .inst_brj_1(inst_brj_1),
        .inst_val_2(inst_val_2), .inst_wen_2(inst_wen_2), .inst_waddr_2(inst_waddr_2), .inst_brj_2(inst_brj_2),
        .inst_acc_1(inst_acc_1), .inst_acc_2(inst_acc_2),
        .rob(rob_if.master),
        .rob_commit_cnt(rob_commit_cnt), .brj_resolved(brj_resolved), .brj_taken(brj_taken),
        .rob_occupancy(rob_occupancy), .spec_active(spec_active), .occ_err(occ_err)
`ifdef RISCV_ROB_ALLOC_PERF_EN
        , .perf_full_stalls(perf_full_stalls), .perf_brj_stalls(perf_brj_stalls)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_occ  = 0;
    bit m_spec = 0;
    bit m_err  = 0;
    int m_full = 0;
    int m_brjs = 0;
    bit e_acc1, e_acc2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit v1, input bit w1, input logic [4:0] a1, input bit b1,
                          input bit v2, input bit w2, input logic [4:0] a2, input bit b2,
                          input bit rdy, input logic [1:0] cm, input bit res, input bit rst);
        inst_val_1 = v1; inst_wen_1 = w1; inst_waddr_1 = a1; inst_brj_1 = b1;
        inst_val_2 = v2; inst_wen_2 = w2; inst_waddr_2 = a2; inst_brj_2 = b2;
        rob_if.rob_alloc_req_rdy = rdy;
        rob_commit_cnt = cm; brj_resolved = res; brj_taken = 1'($urandom);
        reset = rst;
    endtask

    // Settle combinational outputs and compare them against the model.
    task automatic apply();
        int  free;
        bit  go;
        bit  e_wen1, e_wen2, e_sp1, e_sp2;
        logic [4:0] e_p1, e_p2;
        #1;
        free   = ROB_DEPTH - m_occ;
        go     = rob_if.rob_alloc_req_rdy && free >= 2 && !brj_resolved;
        e_acc1 = !reset && go && inst_val_1 && !(inst_brj_1 && m_spec);
        e_acc2 = !reset && go && inst_val_2 && (e_acc1 || !inst_val_1) &&
                 !(inst_brj_2 && (m_spec || (e_acc1 && inst_brj_1)));
        e_wen1 = !reset && inst_wen_1 && inst_waddr_1 != 0;
        e_wen2 = !reset && inst_wen_2 && inst_waddr_2 != 0;
        e_sp1  = !reset && m_spec;
        e_sp2  = !reset && (m_spec || (e_acc1 && inst_brj_1));
        e_p1   = reset ? 5'd0 : inst_waddr_1;
        e_p2   = reset ? 5'd0 : inst_waddr_2;
        check("acc", {30'd0, inst_acc_1, inst_acc_2}, {30'd0, e_acc1, e_acc2});
        check("port1", {24'd0, rob_if.rob_alloc_req_val_1, rob_if.rob_alloc_req_wen_1,
                        rob_if.rob_alloc_req_spec_1, rob_if.rob_alloc_req_preg_1},
                       {24'd0, e_acc1, e_wen1, e_sp1, e_p1});
        check("port2", {24'd0, rob_if.rob_alloc_req_val_2, rob_if.rob_alloc_req_wen_2,
                        rob_if.rob_alloc_req_spec_2, rob_if.rob_alloc_req_preg_2},
                       {24'd0, e_acc2, e_wen2, e_sp2, e_p2});
        if (!reset && (inst_val_1 || inst_val_2) && !(rob_if.rob_alloc_req_rdy && free >= 2)) m_full++;
        if (!reset && m_spec && go && ((inst_val_1 && inst_brj_1) || (inst_val_2 && inst_brj_2))) m_brjs++;
    endtask

    // Advance one clock, update the model, compare registered outputs.
    task automatic clock();
        int n;
        @(posedge clk);
        #1;
        if (reset) begin
            m_occ = 0; m_spec = 0; m_err = 0; m_full = 0; m_brjs = 0;
        end else begin
            if (m_spec && brj_resolved) m_spec = 0;
            else if (!m_spec && ((e_acc1 && inst_brj_1) || (e_acc2 && inst_brj_2))) m_spec = 1;
            n = m_occ + int'(e_acc1) + int'(e_acc2) - int'(rob_commit_cnt);
            if (n < 0)              begin m_err = 1; m_occ = 0;         end
            else if (n > ROB_DEPTH) begin m_err = 1; m_occ = ROB_DEPTH; end
            else                    m_occ = n;
        end
        check("occ", 32'(rob_occupancy), m_occ);
        check("spec_active", 32'(spec_active), 32'(m_spec));
        check("occ_err", 32'(occ_err), 32'(m_err));
`ifdef RISCV_ROB_ALLOC_PERF_EN
        check("perf_full", perf_full_stalls, m_full);
        check("perf_brj", perf_brj_stalls, m_brjs);
`endif
    endtask

    task automatic cyc();
        apply();
        clock();
    endtask

    initial begin
        set_in(1,1,3,0, 1,1,4,0, 1,0,0,1);
        @(posedge clk); #1;
        // Valid inputs during reset must produce nothing.
        apply();
        check("rst_acc", {30'd0, inst_acc_1, inst_acc_2}, 32'd0);
        clock();
        check("rst_occ", 32'(rob_occupancy), 32'd0);
        check("rst_spec", 32'(spec_active), 32'd0);

        // Dual non-branch allocation: 0 -> 2 -> 4.
        set_in(1,1,3,0, 1,1,4,0, 1,0,0,0);
        apply();
        check("dual_acc", {30'd0, inst_acc_1, inst_acc_2}, 32'd3);
        clock();
        check("occ_2", 32'(rob_occupancy), 32'd2);
        cyc();
        check("occ_4", 32'(rob_occupancy), 32'd4);

        // Fill to 30, then 32, then blocked at full, then commit 2 while full.
        repeat (13) cyc();
        check("occ_30", 32'(rob_occupancy), 32'd30);
        cyc();
        check("occ_32", 32'(rob_occupancy), 32'd32);
        apply();
        check("full_block", {30'd0, inst_acc_1, inst_acc_2}, 32'd0);
        clock();
        check("occ_hold", 32'(rob_occupancy), 32'd32);
        set_in(1,1,3,0, 1,1,4,0, 1,2,0,0);
        cyc();
        check("occ_commit", 32'(rob_occupancy), 32'd30);
        // One free entry still stalls a lone slot 1.
        set_in(0,0,0,0, 0,0,0,0, 1,0,0,0);
        set_in(1,1,3,0, 1,1,4,0, 1,0,0,0); cyc(); // 32
        set_in(0,0,0,0, 0,0,0,0, 1,1,0,0); cyc(); // 31
        set_in(1,1,7,0, 0,0,0,0, 1,0,0,0);
        apply();
        check("one_free", {30'd0, inst_acc_1, inst_acc_2}, 32'd0);
        clock();

        // Drain to empty.
        set_in(0,0,0,0, 0,0,0,0, 1,1,0,0); cyc();
        set_in(0,0,0,0, 0,0,0,0, 1,2,0,0);
        repeat (15) cyc();
        check("drained", 32'(rob_occupancy), 32'd0);

        // Branch in slot 1 plus add in slot 2.
        set_in(1,0,0,1, 1,1,5,0, 1,0,0,0);
        apply();
        check("br_acc", {30'd0, inst_acc_1, inst_acc_2}, 32'd3);
        check("br_spec2", 32'(rob_if.rob_alloc_req_spec_2), 32'd1);
        check("br_spec1", 32'(rob_if.rob_alloc_req_spec_1), 32'd0);
        clock();
        check("spec_on", 32'(spec_active), 32'd1);
        set_in(1,0,0,1, 0,0,0,0, 1,0,0,0);
        repeat (2) begin
            apply();
            check("br2_stall", 32'(inst_acc_1), 32'd0);
            clock();
        end
        set_in(1,0,0,1, 0,0,0,0, 1,0,1,0);
        apply();
        check("res_block", 32'(inst_acc_1), 32'd0);
        clock();
        check("spec_off", 32'(spec_active), 32'd0);
        set_in(1,0,0,1, 0,0,0,0, 1,0,0,0);
        apply();
        check("br2_acc", 32'(inst_acc_1), 32'd1);
        check("br2_spec1", 32'(rob_if.rob_alloc_req_spec_1), 32'd0);
        clock();
        set_in(0,0,0,0, 0,0,0,0, 1,2,1,0); cyc();
        set_in(0,0,0,0, 0,0,0,0, 1,2,0,0); cyc();

        // Slot 2 alone writing x0.
        set_in(0,0,0,0, 1,1,0,0, 1,0,0,0);
        apply();
        check("s2_alone", {28'd0, rob_if.rob_alloc_req_val_1, rob_if.rob_alloc_req_val_2,
                           rob_if.rob_alloc_req_wen_2, inst_acc_2}, 32'b0101);
        clock();

        // Underflow: drain then commit from empty.
        set_in(0,0,0,0, 0,0,0,0, 1,1,0,0); cyc();
        cyc();
        check("uflow_err", 32'(occ_err), 32'd1);
        check("uflow_occ", 32'(rob_occupancy), 32'd0);
        set_in(0,0,0,0, 0,0,0,0, 1,0,0,0); cyc();
        check("err_sticky", 32'(occ_err), 32'd1);
        set_in(0,0,0,0, 0,0,0,0, 1,0,0,1); cyc();
        check("err_clear", 32'(occ_err), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int cmax;
            logic [1:0] cm;
            cmax = (m_occ < 2) ? m_occ : 2;
            cm = 2'($urandom_range(cmax, 0));
            if ($urandom_range(99, 0) < 3) cm = 2'($urandom_range(2, 0));
            set_in(1'($urandom_range(99,0) < 80), 1'($urandom), 5'($urandom), 1'($urandom_range(99,0) < 25),
                   1'($urandom_range(99,0) < 80), 1'($urandom), 5'($urandom), 1'($urandom_range(99,0) < 25),
                   1'($urandom_range(99,0) < 85), cm, 1'($urandom_range(99,0) < 20),
                   1'($urandom_range(99,0) < 2));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
